// File: rtl/jtbubl_sdram_pkg.sv
// jtbubl_sdram_pkg: shared types, slot indices and round-robin helper for the SDRAM scheduler
package jtbubl_sdram_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  localparam int MAIN = 0;
  localparam int SUB  = 1;
  localparam int MCU  = 2;
  localparam int SND  = 3;
  localparam int GFX  = 4;
  function automatic logic [2:0] rr_pick(input logic [7:0] miss, input logic [2:0] ptr, input int n);
    logic [2:0] r;
    logic f;
    int idx;
    r = ptr;
    f = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && !f && miss[idx]) begin
        r = 3'(idx);
        f = 1'b1;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/jtbubl_sdram_slot.sv
// jtbubl_sdram_slot: one-entry tagged read buffer with combinational hit detect
module jtbubl_sdram_slot #(
  parameter int AW = 22
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fill,
  input  logic          inv,
  input  logic [AW-1:0] fill_addr,
  input  logic [31:0]   fill_data,
  input  logic [AW-1:0] addr,
  output logic          ok,
  output logic [31:0]   dout
);
  logic valid;
  logic [AW-1:0] tag;
  // invalidate wins over fill so an aborted transfer never lands
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      dout  <= '0;
    end else if (inv) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_addr;
      dout  <= fill_data;
    end
  assign ok = valid && tag == addr;
endmodule

// File: rtl/jtbubl_sdram_sched.sv
// jtbubl_sdram_sched: round-robin SDRAM read scheduler over N buffered ROM clients
module jtbubl_sdram_sched #(
  parameter int N    = 5,
  parameter int AW   = 22,
  parameter int TOUT = 63
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            downloading,
  input  logic            loop_rst,
  input  logic [N-1:0]    slot_cs,
  input  logic [N*AW-1:0] slot_addr,
  output logic [N-1:0]    slot_ok,
  output logic [N*32-1:0] slot_dout,
  output logic            sdram_req,
  output logic [AW-1:0]   sdram_addr,
  input  logic            sdram_ack,
  input  logic            data_rdy,
  input  logic [31:0]     data_read,
  output logic            refresh_en,
  output logic [2:0]      busy_slot
);
  import jtbubl_sdram_pkg::*;
  localparam int WW = $clog2(TOUT + 1);
  state_t st, st_nx;
  logic [2:0] sel, sel_nx, rr, rr_nx, pick;
  logic [AW-1:0] addr_nx;
  logic req_nx, fill_en, halt;
  logic [WW-1:0] wd, wd_nx;
  logic [N-1:0] miss, fill;
  logic [AW-1:0] addr_a [N];
  assign halt       = downloading | loop_rst;
  assign miss       = slot_cs & ~slot_ok;
  assign pick       = rr_pick(8'(miss), rr, N);
  assign refresh_en = st == IDLE && miss == '0;
  assign busy_slot  = sel;
  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_slot
      assign addr_a[i] = slot_addr[i*AW +: AW];
      assign fill[i]   = fill_en && sel == 3'(i);
      jtbubl_sdram_slot #(.AW(AW)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .fill      (fill[i]),
        .inv       (halt),
        .fill_addr (sdram_addr),
        .fill_data (data_read),
        .addr      (addr_a[i]),
        .ok        (slot_ok[i]),
        .dout      (slot_dout[i*32 +: 32])
      );
    end
  endgenerate
  // next-state: grant on miss, wait for ack, then data or watchdog reissue
  always_comb begin
    st_nx   = st;
    sel_nx  = sel;
    rr_nx   = rr;
    addr_nx = sdram_addr;
    req_nx  = sdram_req;
    wd_nx   = wd;
    fill_en = 1'b0;
    if (halt) begin
      st_nx  = IDLE;
      req_nx = 1'b0;
    end else begin
      case (st)
        IDLE: if (|miss) begin
          sel_nx  = pick;
          addr_nx = addr_a[pick];
          req_nx  = 1'b1;
          st_nx   = REQ;
        end
        REQ: if (sdram_ack) begin
          req_nx  = 1'b0;
          wd_nx   = '0;
          fill_en = data_rdy;
          st_nx   = data_rdy ? IDLE : WAIT;
        end
        WAIT: begin
          fill_en = data_rdy;
          wd_nx   = wd + 1'b1;
          if (data_rdy) st_nx = IDLE;
          else if (wd == WW'(TOUT - 1)) begin
            req_nx = 1'b1;
            st_nx  = REQ;
          end
        end
        default: st_nx = IDLE;
      endcase
    end
    if (fill_en) rr_nx = sel == 3'(N - 1) ? 3'd0 : sel + 3'd1;
  end
  // scheduler state register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st         <= IDLE;
      sel        <= '0;
      rr         <= '0;
      sdram_addr <= '0;
      sdram_req  <= 1'b0;
      wd         <= '0;
    end else begin
      st         <= st_nx;
      sel        <= sel_nx;
      rr         <= rr_nx;
      sdram_addr <= addr_nx;
      sdram_req  <= req_nx;
      wd         <= wd_nx;
    end
endmodule

// File: tb/tb_jtbubl_sdram_sched.sv
// tb_jtbubl_sdram_sched: table-driven and scoreboard checks of the SDRAM scheduler
module tb_jtbubl_sdram_sched;
  localparam int N = 5, AW = 22, TOUT = 63;
  logic clk = 1'b0, rst = 1'b0, downloading = 1'b0, loop_rst = 1'b0;
  logic sdram_ack = 1'b0, data_rdy = 1'b0;
  logic [N-1:0] slot_cs = '0, slot_ok;
  logic [N*AW-1:0] slot_addr = '0;
  logic [N*32-1:0] slot_dout;
  logic sdram_req, refresh_en;
  logic [AW-1:0] sdram_addr;
  logic [31:0] data_read = '0;
  logic [2:0] busy_slot;
  int n_chk = 0, n_fail = 0;
  typedef struct {logic [2:0] slot; logic [AW-1:0] addr;} gnt_t;
  typedef struct {logic [N-1:0] cs; logic [AW-1:0] base; int cnt; logic [19:0] ord;} row_t;
  gnt_t sb[$];
  row_t rows[5];
  logic [31:0] exp_dout [N];

  always #5 clk = ~clk;

  jtbubl_sdram_sched #(.N(N), .AW(AW), .TOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .downloading(downloading), .loop_rst(loop_rst),
    .slot_cs(slot_cs), .slot_addr(slot_addr), .slot_ok(slot_ok), .slot_dout(slot_dout),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_rdy(data_rdy), .data_read(data_read), .refresh_en(refresh_en), .busy_slot(busy_slot)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dat(input logic [AW-1:0] a);
    return a == 22'h1C000 ? 32'hDEADBEEF : {10'h2A5, a};
  endfunction

  task automatic set_addr(input int s, input logic [AW-1:0] a);
    slot_addr[s*AW +: AW] = a;
  endtask

  // wait for the next grant, compare it with the scoreboard head, then ack and return data
  task automatic serve();
    gnt_t g;
    int w;
    logic [31:0] d;
    w = 0;
    while (!sdram_req && w < 20) begin
      step();
      w++;
    end
    check("req_latency", 64'(w), 1);
    if (!sdram_req || sb.size() == 0) return;
    g = sb.pop_front();
    check("grant_slot", 64'(busy_slot), 64'(g.slot));
    check("grant_addr", 64'(sdram_addr), 64'(g.addr));
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    check("ack_drop", 64'(sdram_req), 0);
    d = dat(g.addr);
    data_read = d;
    data_rdy = 1'b1;
    step();
    data_rdy = 1'b0;
    #1;
    exp_dout[g.slot] = d;
    check("fill_ok", 64'(slot_ok[g.slot]), 1);
    check("fill_dout", 64'(slot_dout[g.slot*32 +: 32]), 64'(d));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    gnt_t g;
    int cnt;
    // rows: miss mask, address base (slot s at base + s*0x40), grant count, grant order nibbles
    rows[0] = '{5'b10011, 22'h010000, 3, 20'h00410};
    rows[1] = '{5'b00010, 22'h011000, 1, 20'h00001};
    rows[2] = '{5'b10011, 22'h012000, 3, 20'h00104};
    rows[3] = '{5'b00100, 22'h01BF80, 1, 20'h00002};
    rows[4] = '{5'b11111, 22'h014000, 5, 20'h21043};
    for (int s = 0; s < N; s++) exp_dout[s] = '0;
    #1 rst = 1'b1;
    #2;
    check("rst_req", 64'(sdram_req), 0);
    check("rst_addr", 64'(sdram_addr), 0);
    check("rst_busy", 64'(busy_slot), 0);
    check("rst_ok", 64'(slot_ok), 0);
    check("rst_refresh", 64'(refresh_en), 1);
    check("rst_dout", 64'(slot_dout[63:0]) | 64'(slot_dout[159:128]), 0);
    step();
    rst = 1'b0;
    step();
    // table-driven round-robin rows
    for (int r = 0; r < 5; r++) begin
      for (int s = 0; s < N; s++)
        if (rows[r].cs[s]) set_addr(s, rows[r].base + AW'({s[2:0], 6'd0}));
      slot_cs = rows[r].cs;
      for (int k = 0; k < rows[r].cnt; k++) begin
        g.slot = rows[r].ord[k*4 +: 3];
        g.addr = rows[r].base + AW'({g.slot, 6'd0});
        sb.push_back(g);
      end
      for (int k = 0; k < rows[r].cnt; k++) serve();
      check("row_ok", 64'(slot_ok & rows[r].cs), 64'(rows[r].cs));
      cnt = 0;
      repeat (4) begin
        step();
        cnt += int'(sdram_req);
      end
      check("row_noreq", 64'(cnt), 0);
      slot_cs = '0;
    end
    // address change while the fill is outstanding
    set_addr(0, 22'h100);
    slot_cs = 5'b00001;
    step();
    check("chg_req", 64'(sdram_req), 1);
    check("chg_addr", 64'(sdram_addr), 22'h100);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    set_addr(0, 22'h102);
    data_read = 32'h0BADF00D;
    data_rdy = 1'b1;
    step();
    data_rdy = 1'b0;
    #1;
    check("chg_stale_ok", 64'(slot_ok[0]), 0);
    check("chg_stale_dout", 64'(slot_dout[31:0]), 32'h0BADF00D);
    g = '{3'd0, 22'h102};
    sb.push_back(g);
    serve();
    set_addr(0, 22'h104);
    #1;
    check("hit_fall", 64'(slot_ok[0]), 0);
    set_addr(0, 22'h102);
    #1;
    check("hit_rise", 64'(slot_ok[0]), 1);
    slot_cs = '0;
    step();
    // watchdog reissue then simultaneous ack and data
    set_addr(1, 22'h2000);
    slot_cs = 5'b00010;
    step();
    check("wd_req", 64'(sdram_req), 1);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    cnt = int'(sdram_req);
    repeat (TOUT - 1) begin
      step();
      cnt += int'(sdram_req);
    end
    check("wd_quiet", 64'(cnt), 0);
    step();
    check("wd_reissue", 64'(sdram_req), 1);
    check("wd_addr", 64'(sdram_addr), 22'h2000);
    sdram_ack = 1'b1;
    data_rdy = 1'b1;
    data_read = dat(22'h2000);
    step();
    sdram_ack = 1'b0;
    data_rdy = 1'b0;
    #1;
    check("wd_fill_ok", 64'(slot_ok[1]), 1);
    check("wd_fill_dout", 64'(slot_dout[63:32]), 64'(dat(22'h2000)));
    check("wd_req_low", 64'(sdram_req), 0);
    slot_cs = '0;
    step();
    // refresh gating and download abort
    check("ref_idle", 64'(refresh_en), 1);
    set_addr(3, 22'h3000);
    slot_cs = 5'b01000;
    #1;
    check("ref_miss", 64'(refresh_en), 0);
    step();
    check("dl_req", 64'(sdram_req), 1);
    check("ref_req", 64'(refresh_en), 0);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    check("ref_wait", 64'(refresh_en), 0);
    downloading = 1'b1;
    step();
    check("dl_req_low", 64'(sdram_req), 0);
    check("dl_ok", 64'(slot_ok), 0);
    data_read = 32'h12345678;
    data_rdy = 1'b1;
    step();
    data_rdy = 1'b0;
    check("dl_ignore", 64'(slot_dout[127:96]), 64'(exp_dout[3]));
    cnt = 0;
    repeat (3) begin
      step();
      cnt += int'(sdram_req);
    end
    check("dl_idle", 64'(cnt), 0);
    downloading = 1'b0;
    g = '{3'd3, 22'h3000};
    sb.push_back(g);
    serve();
    check("ref_done", 64'(refresh_en), 1);
    // loop_rst invalidates and holds off scheduling
    loop_rst = 1'b1;
    step();
    check("lr_ok", 64'(slot_ok), 0);
    cnt = int'(sdram_req);
    step();
    cnt += int'(sdram_req);
    check("lr_idle", 64'(cnt), 0);
    loop_rst = 1'b0;
    sb.push_back(g);
    serve();
    slot_cs = '0;
    step();
    check("sb_empty", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/jtbubl_sdram_sched.md
Name: jtbubl_sdram_sched

Overview:
- Round-robin scheduler that shares the single SDRAM read port between N ROM clients: main, sub, MCU and sound CPUs, plus the GFX fetcher.
- Each client owns a one-entry 32-bit read buffer with an address tag. The block issues SDRAM requests only on a buffer miss, then fills the buffer from the returned data.
- Sits between the game-level ROM clients and the SDRAM controller, in place of a per-game slot mux. Addresses arrive already offset into the SDRAM map.

Parameters:
- N, 5, number of client slots (1..8).
- AW, 22, SDRAM address width (16-bit word addresses).
- TOUT, 63, watchdog in clk cycles from ack to data_rdy before the request is reissued.

Ports:
- clk  in  1  system clock, SDRAM domain
- rst  in  1  asynchronous, active-high reset
- downloading  in  1  ROM download in progress; scheduler idles
- loop_rst  in  1  SDRAM init loop; scheduler idles
- slot_cs  in  N  per-slot read request, level
- slot_addr  in  N*AW  packed per-slot address; slot i occupies bits [i*AW +: AW]
- slot_ok  out  N  buffer i valid and its tag equals the current slot_addr[i]
- slot_dout  out  N*32  packed per-slot buffer data
- sdram_req  out  1  read request to SDRAM controller
- sdram_addr  out  AW  request address
- sdram_ack  in  1  controller accepted the request (1-cycle pulse)
- data_rdy  in  1  data_read valid (1-cycle pulse)
- data_read  in  32  SDRAM read data
- refresh_en  out  1  controller may refresh now
- busy_slot  out  3  index of the slot being served (debug)

Behaviour:
- **Reset** (async): state IDLE; sdram_req=0; sdram_addr=0; all valid bits=0, tags=0, buffers=0; rr pointer=0; refresh_en=1; busy_slot=0; slot_ok=0.
- **Hit**: slot_ok[i] = valid[i] & tag[i]==slot_addr[i], combinational. It rises the same cycle the address matches and falls the same cycle the address changes, with no register delay. slot_ok does not depend on slot_cs.
- **Miss**: miss[i] = slot_cs[i] & ~slot_ok[i].
- **IDLE**:
  - If downloading|loop_rst, stay in IDLE.
  - Else, if any miss, pick the first miss at or after the rr pointer, wrapping modulo N.
  - Register sel, sdram_addr = slot_addr[sel] and busy_slot = sel; set sdram_req=1; go to REQ.
  - refresh_en=1 only in IDLE with no miss.
- **REQ**: hold sdram_req and sdram_addr stable until sdram_ack. On ack: sdram_req=0, clear the watchdog, go to WAIT.
- **WAIT**:
  - On data_rdy: buf[sel] <= data_read, tag[sel] <= sdram_addr, valid[sel] <= 1; rr <= sel+1 (mod N); go to IDLE.
  - The filled slot shows slot_ok the cycle after data_rdy, provided its address is unchanged.
- **Address change mid-fill**: if the client changes its address while in REQ/WAIT, the fill still completes with the old address as tag. slot_ok stays 0 and the slot re-misses in IDLE. Requests are never aborted.
- **Watchdog**: in WAIT, if no data_rdy within TOUT cycles, reassert sdram_req with the same address and return to REQ.
- **downloading or loop_rst asserted in any state**:
  - Next cycle: state IDLE, sdram_req=0, all valid=0.
  - A pending data_rdy is ignored.
  - The rr pointer is kept.
- **Simultaneous events**:
  - sdram_ack together with data_rdy in REQ: treat as ack followed by data, i.e. fill immediately and go to IDLE.
  - data_rdy while in IDLE or REQ without prior ack: ignored.
- **Latency**: miss-to-req is 1 cycle. A miss at cycle t sees sdram_req at t+1.
- **Fairness**: worst-case wait for a slot is N-1 other fills.

Decomposition:
- **Shared package jtbubl_sdram_pkg**:
  - State enum {IDLE, REQ, WAIT}.
  - Localparams for slot indices: MAIN=0, SUB=1, MCU=2, SND=3, GFX=4.
  - Function rr_pick(miss, ptr) returning the next index.
- **Sub-module jtbubl_sdram_slot** (instantiated N times): valid/tag/data register plus hit comparator, with a fill strobe input and an invalidate input.
- **Top module**: FSM, round-robin and watchdog.

Test Plan:
- **Single miss**: slot 2 cs=1, addr=0x1C000; everything else idle. Expect sdram_req at t+1 with sdram_addr=0x1C000. After ack, then data_rdy with 0xDEADBEEF: slot_ok[2]=1 and slot_dout[2]=0xDEADBEEF; no further req while the address is held.
- **Round-robin**: slots 0, 1 and 4 all missing, rr=0, each fill answered after ack. Grant order is 0,1,4. After refilling with new addresses starting at rr=2, order is 4,0,1.
- **Address change mid-fill**: slot 0 changes addr 0x100→0x102 during WAIT. The fill lands with tag 0x100 and slot_ok[0] stays 0. A second req at 0x102 follows, after which slot_ok[0]=1.
- **Watchdog**: ack given, data_rdy withheld for 64 cycles. Expect sdram_req reasserted with the same address at cycle TOUT+1; the late data then fills normally.
- **Download abort**: downloading=1 during WAIT. Next cycle sdram_req=0 and all slot_ok=0. A following data_rdy leaves the buffers untouched; scheduling resumes when downloading=0.
- **Refresh gating**: refresh_en=1 in IDLE with no cs. With slot 3 missing, refresh_en=0 the same cycle and stays 0 until the fill completes.
